// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the bimodal branch predictor: counter encodings,
// default table geometry and the PC index/tag slicing used by lookup and training.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_e;

  localparam cnt_e CNT_RESET = WNT;
  localparam int   DEF_IDX_W = 6;
  localparam int   DEF_TAG_W = 8;

  // PCs are widened to 64 bits by callers so one helper serves any ADDR_W up to 64.
  function automatic logic [63:0] pc_index(input logic [63:0] pc, input int unsigned idx_w);
    return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int unsigned idx_w,
                                         input int unsigned tag_w);
    return (pc >> (idx_w + 2)) & ((64'd1 << tag_w) - 64'd1);
  endfunction

  function automatic cnt_e cnt_inc(input cnt_e c);
    return (c == ST) ? ST : cnt_e'(c + 2'd1);
  endfunction

  function automatic cnt_e cnt_dec(input cnt_e c);
    return (c == SNT) ? SNT : cnt_e'(c - 2'd1);
  endfunction

endpackage

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer: combinational read port, one synchronous
// write port, and a synchronous clear of all valid bits.
module bp_btb
  import branch_predictor_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int TAG_W  = DEF_TAG_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [TAG_W-1:0]  rd_tag,
  output logic              rd_hit,
  output logic [ADDR_W-1:0] rd_target,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [ADDR_W-1:0] wr_target
);

  localparam int NUM_ENT = 1 << IDX_W;

  logic [NUM_ENT-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [NUM_ENT];
  logic [ADDR_W-1:0]  tgt_q [NUM_ENT];

  assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_target = tgt_q[rd_idx];

  always_comb begin
    valid_d = valid_q;
    if (wr_en) valid_d[wr_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Tag/target payload needs no reset: it is only trusted behind a valid bit.
  always_ff @(posedge clk) begin
    if (wr_en && !clr) begin
      tag_q[wr_idx] <= wr_tag;
      tgt_q[wr_idx] <= wr_target;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal direction predictor with BTB: 0-cycle lookup for the IF PC, training from
// EX resolutions, and a registered one-cycle mispredict/redirect for the IF/ID flush.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              ex_br_valid,
  input  logic [ADDR_W-1:0] ex_br_pc,
  input  logic              ex_br_taken,
  input  logic [ADDR_W-1:0] ex_br_target,
  input  logic              ex_pred_taken,
  input  logic [ADDR_W-1:0] ex_pred_target,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  mispred_cnt
);

  localparam int NUM_ENT = 1 << IDX_W;

  logic [IDX_W-1:0]  if_idx, ex_idx;
  logic [TAG_W-1:0]  if_tag, ex_tag;
  logic              btb_hit;
  logic [ADDR_W-1:0] btb_target;
  logic              update_en, miss, flush;

  cnt_e              cnt_q [NUM_ENT];
  cnt_e              cnt_d [NUM_ENT];
  logic              mispredict_q, mispredict_d;
  logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0]  mispred_cnt_q, mispred_cnt_d;

  assign if_idx = IDX_W'(pc_index(64'(if_pc), IDX_W));
  assign if_tag = TAG_W'(pc_tag(64'(if_pc), IDX_W, TAG_W));
  assign ex_idx = IDX_W'(pc_index(64'(ex_br_pc), IDX_W));
  assign ex_tag = TAG_W'(pc_tag(64'(ex_br_pc), IDX_W, TAG_W));

  bp_btb #(
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W)
  ) u_btb (
    .clk       (clk),
    .clr       (reset),
    .rd_idx    (if_idx),
    .rd_tag    (if_tag),
    .rd_hit    (btb_hit),
    .rd_target (btb_target),
    .wr_en     (update_en && ex_br_taken && !reset),
    .wr_idx    (ex_idx),
    .wr_tag    (ex_tag),
    .wr_target (ex_br_target)
  );

  // No bypass: lookup always sees the state registered before this edge.
  assign pred_taken  = btb_hit && cnt_q[if_idx][1];
  assign pred_target = pred_taken ? btb_target : if_pc + ADDR_W'(4);

  // The instruction in EX right after a flush is wrong-path, so it is squashed.
  assign update_en = ex_br_valid && !mispredict_q;
  assign miss      = (ex_pred_taken != ex_br_taken) ||
                     (ex_br_taken && (ex_pred_target != ex_br_target));
  assign flush     = update_en && miss;

  always_comb begin
    cnt_d         = cnt_q;
    mispredict_d  = flush;
    redirect_pc_d = redirect_pc_q;
    mispred_cnt_d = mispred_cnt_q;
    if (update_en) begin
      cnt_d[ex_idx] = ex_br_taken ? cnt_inc(cnt_q[ex_idx]) : cnt_dec(cnt_q[ex_idx]);
    end
    if (flush) begin
      redirect_pc_d = ex_br_taken ? ex_br_target : ex_br_pc + ADDR_W'(4);
      if (mispred_cnt_q != '1) mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENT; i++) cnt_q[i] <= CNT_RESET;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
      mispred_cnt_q <= '0;
    end else begin
      cnt_q         <= cnt_d;
      mispredict_q  <= mispredict_d;
      redirect_pc_q <= redirect_pc_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign mispredict  = mispredict_q;
  assign redirect_pc = redirect_pc_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor; expected values are worked out by hand
// from the counter/BTB rules for a 64-entry table (index = pc[7:2], tag = pc[15:8]).
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_br_valid;
  logic [31:0] ex_br_pc;
  logic        ex_br_taken;
  logic [31:0] ex_br_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [15:0] mispred_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk            (clk),
    .reset          (reset),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_br_valid    (ex_br_valid),
    .ex_br_pc       (ex_br_pc),
    .ex_br_taken    (ex_br_taken),
    .ex_br_target   (ex_br_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .mispred_cnt    (mispred_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("vec %0d %s: 0x%08h ok", n_vec, tag, got);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                         input logic ptaken, input logic [31:0] ptgt);
    ex_br_valid    = 1'b1;
    ex_br_pc       = pc;
    ex_br_taken    = taken;
    ex_br_target   = tgt;
    ex_pred_taken  = ptaken;
    ex_pred_target = ptgt;
    step();
    ex_br_valid = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic exp_taken,
                      input logic [31:0] exp_tgt);
    if_pc = pc;
    #1;
    chk({tag, ".pred_taken"}, {31'd0, pred_taken}, {31'd0, exp_taken});
    chk({tag, ".pred_target"}, pred_target, exp_tgt);
  endtask

  task automatic flush_state(input string tag, input logic exp_mp, input logic [31:0] exp_rd,
                             input logic [15:0] exp_cnt);
    chk({tag, ".mispredict"}, {31'd0, mispredict}, {31'd0, exp_mp});
    chk({tag, ".redirect_pc"}, redirect_pc, exp_rd);
    chk({tag, ".mispred_cnt"}, {16'd0, mispred_cnt}, {16'd0, exp_cnt});
  endtask

  initial begin
    reset = 1'b1; if_pc = 32'h100; ex_br_valid = 1'b0; ex_br_pc = '0;
    ex_br_taken = 1'b0; ex_br_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
    step(); step();
    reset = 1'b0;
    look("reset", 32'h100, 1'b0, 32'h104);
    flush_state("reset", 1'b0, 32'h0, 16'd0);

    // Cold branch taken to 0x80: WNT->WT, BTB filled, one mispredict.
    resolve(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    flush_state("first_taken", 1'b1, 32'h80, 16'd1);
    look("first_taken", 32'h100, 1'b1, 32'h80);
    step();
    flush_state("pulse_end", 1'b0, 32'h80, 16'd1);

    // Three correctly predicted taken: WT->ST->ST->ST.
    for (int i = 0; i < 3; i++) begin
      resolve(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
      chk("taken_train.mispredict", {31'd0, mispredict}, 32'd0);
    end
    look("saturate_st", 32'h100, 1'b1, 32'h80);
    flush_state("no_miss_hold", 1'b0, 32'h80, 16'd1);

    // Not-taken training: ST->WT (still taken) ->WNT->SNT->SNT.
    resolve(32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
    look("nt1", 32'h100, 1'b1, 32'h80);
    resolve(32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
    look("nt2", 32'h100, 1'b0, 32'h104);
    resolve(32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
    resolve(32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
    look("nt4", 32'h100, 1'b0, 32'h104);
    // One taken from SNT only reaches WNT.
    resolve(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
    look("sat_snt", 32'h100, 1'b0, 32'h104);
    chk("sat_snt.mispred_cnt", {16'd0, mispred_cnt}, 32'd1);

    // Squash: miss at 0x104, then a back-to-back miss that must be ignored.
    ex_br_valid = 1'b1; ex_br_pc = 32'h104; ex_br_taken = 1'b1; ex_br_target = 32'h300;
    ex_pred_taken = 1'b0; ex_pred_target = 32'h108;
    step();
    flush_state("squash_first", 1'b1, 32'h300, 16'd2);
    ex_br_target = 32'h500;
    step();
    ex_br_valid = 1'b0;
    flush_state("squash_ignored", 1'b0, 32'h300, 16'd2);
    look("squash_ignored", 32'h104, 1'b1, 32'h300);
    // Counter must be WT (not ST): one not-taken drops it to WNT.
    resolve(32'h104, 1'b0, 32'h300, 1'b0, 32'h108);
    look("squash_cnt", 32'h104, 1'b0, 32'h108);

    // Not-taken miss redirects to pc+4.
    resolve(32'h104, 1'b0, 32'h300, 1'b1, 32'h300);
    flush_state("nt_miss", 1'b1, 32'h108, 16'd3);
    step();
    // Direction right, target wrong.
    resolve(32'h104, 1'b1, 32'h400, 1'b1, 32'h300);
    flush_state("tgt_miss", 1'b1, 32'h400, 16'd4);
    step();

    // Alias: 0x200 shares index 0 with 0x100 (WNT) but has another tag.
    resolve(32'h200, 1'b1, 32'h900, 1'b0, 32'h204);
    flush_state("alias", 1'b1, 32'h900, 16'd5);
    step();
    look("alias_old", 32'h100, 1'b0, 32'h104);
    look("alias_new", 32'h200, 1'b1, 32'h900);

    // Same-index lookup during update sees pre-update state.
    if_pc = 32'h200;
    ex_br_valid = 1'b1; ex_br_pc = 32'h200; ex_br_taken = 1'b0; ex_br_target = 32'h900;
    ex_pred_taken = 1'b0; ex_pred_target = 32'h204;
    #1;
    chk("no_bypass.pred_taken", {31'd0, pred_taken}, 32'd1);
    step();
    ex_br_valid = 1'b0;
    look("after_update", 32'h200, 1'b0, 32'h204);

    look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

    // Reset wins over a concurrent missing resolution.
    reset = 1'b1;
    ex_br_valid = 1'b1; ex_br_pc = 32'h200; ex_br_taken = 1'b1; ex_br_target = 32'h40;
    ex_pred_taken = 1'b0; ex_pred_target = 32'h204;
    step();
    ex_br_valid = 1'b0;
    reset = 1'b0;
    flush_state("reset_mid", 1'b0, 32'h0, 16'd0);
    look("reset_mid_a", 32'h200, 1'b0, 32'h204);
    look("reset_mid_b", 32'h104, 1'b0, 32'h108);
    step();
    flush_state("reset_after", 1'b0, 32'h0, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
